// File: rtl/avalon_prefetch_pkg.sv
// Shared helpers for the sequential instruction prefetcher.
package avalon_prefetch_pkg;

   // Width of a counter that must hold 0..depth inclusive.
   function automatic int cnt_w(input int depth);
      return $clog2(depth + 1);
   endfunction

   // Next word address; callers truncate to their address width, which gives the modulo wrap.
   function automatic logic [63:0] word_inc(input logic [63:0] a);
      return a + 64'd1;
   endfunction

endpackage

// File: rtl/avalon_prefetch_fifo.sv
// Prefetch data buffer: synchronous FIFO with show-ahead head word and priority clear.
module avalon_prefetch_fifo #(
   parameter int DEPTH      = 4,
   parameter int DATA_WIDTH = 32,
   parameter int CNT_W      = 3
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  clear_i,
   input  logic                  push_i,
   input  logic                  pop_i,
   input  logic [DATA_WIDTH-1:0] data_i,
   output logic [DATA_WIDTH-1:0] data_o,
   output logic [CNT_W-1:0]      count_o
);
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0]      wr_q, rd_q;
   logic [CNT_W-1:0]      cnt_q;

   always_ff @(posedge clk_i) begin
      if (rst_i || clear_i) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (push_i) wr_q <= wr_q + 1'b1;
         if (pop_i)  rd_q <= rd_q + 1'b1;
         cnt_q <= cnt_q + CNT_W'(push_i) - CNT_W'(pop_i);
      end
   end

   always_ff @(posedge clk_i) begin
      if (push_i && !clear_i) mem_q[wr_q] <= data_i;
   end

   assign data_o  = mem_q[rd_q];
   assign count_o = cnt_q;
endmodule

// File: rtl/avalon_instr_prefetch.sv
// Sequential instruction prefetcher between the core's instruction master and the Avalon fabric.
module avalon_instr_prefetch
   import avalon_prefetch_pkg::*;
#(
   parameter int DEPTH      = 4,
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  flush_i,
   input  logic [ADDR_WIDTH-1:0] s_address,
   input  logic                  s_read,
   output logic                  s_waitrequest,
   output logic [DATA_WIDTH-1:0] s_readdata,
   output logic                  s_readdatavalid,
   output logic [ADDR_WIDTH-1:0] m_address,
   output logic                  m_read,
   input  logic                  m_waitrequest,
   input  logic [DATA_WIDTH-1:0] m_readdata,
   input  logic                  m_readdatavalid
);
   localparam int CNT_W  = cnt_w(DEPTH);
   // Repeated redirects can stack discards; the wider counter plus an issue guard keeps it from wrapping.
   localparam int DROP_W = CNT_W + 2;
   localparam logic [DROP_W-1:0] DROP_LIM = DROP_W'((1 << DROP_W) - DEPTH - 1);

   logic                  head_valid_q, head_valid_d;
   logic [ADDR_WIDTH-1:0] head_addr_q, head_addr_d;
   logic [ADDR_WIDTH-1:0] fetch_addr_q, fetch_addr_d;
   logic [ADDR_WIDTH-1:0] m_addr_q, m_addr_d;
   logic [CNT_W-1:0]      live_q, live_d, buf_cnt, buf_d;
   logic [DROP_W-1:0]     drop_q, drop_d;
   logic                  m_read_q, m_read_d;
   logic                  stale_q, stale_d;
   logic                  rdv_q;
   logic [DATA_WIDTH-1:0] rdata_q, fifo_head;

   logic match, hit, redirect, clear, accept, push, drop_resp;

   assign match     = s_read && head_valid_q && (s_address == head_addr_q);
   assign hit       = match && (buf_cnt != '0) && !flush_i;
   assign redirect  = s_read && !match;
   assign clear     = flush_i || redirect;
   assign accept    = m_read_q && !m_waitrequest;
   assign drop_resp = m_readdatavalid && (drop_q != '0);
   assign push      = m_readdatavalid && (drop_q == '0) && !clear;

   assign s_waitrequest   = s_read && !hit;
   assign s_readdata      = rdata_q;
   assign s_readdatavalid = rdv_q;
   assign m_address       = m_addr_q;
   assign m_read          = m_read_q;

   always_comb begin
      head_valid_d = head_valid_q;
      head_addr_d  = head_addr_q;
      fetch_addr_d = fetch_addr_q;
      live_d       = live_q;
      drop_d       = drop_q;
      stale_d      = stale_q;
      buf_d        = buf_cnt + CNT_W'(push) - CNT_W'(hit);
      m_read_d     = m_read_q;
      m_addr_d     = m_addr_q;

      if (clear) begin
         head_valid_d = !flush_i;
         head_addr_d  = s_address;
         fetch_addr_d = s_address;
         live_d       = '0;
         buf_d        = '0;
         // Everything in flight, including an acceptance or response this cycle, is old-stream.
         drop_d       = drop_q + DROP_W'(live_q) + DROP_W'(accept) - DROP_W'(m_readdatavalid);
         stale_d      = m_read_q && !accept;
      end else begin
         if (hit) head_addr_d = ADDR_WIDTH'(word_inc(64'(head_addr_q)));
         if (accept && !stale_q) fetch_addr_d = ADDR_WIDTH'(word_inc(64'(fetch_addr_q)));
         live_d  = live_q + CNT_W'(accept && !stale_q) - CNT_W'(m_readdatavalid && (drop_q == '0));
         drop_d  = drop_q + DROP_W'(accept && stale_q) - DROP_W'(drop_resp);
         if (accept) stale_d = 1'b0;
      end

      // A request held by the fabric must stay frozen until accepted.
      if (m_read_q && m_waitrequest) begin
         m_read_d = 1'b1;
         m_addr_d = m_addr_q;
      end else begin
         m_read_d = head_valid_d && (drop_d < DROP_LIM) &&
                    (((CNT_W+1)'(buf_d) + (CNT_W+1)'(live_d)) < (CNT_W+1)'(DEPTH));
         m_addr_d = fetch_addr_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         head_valid_q <= 1'b0;
         head_addr_q  <= '0;
         fetch_addr_q <= '0;
         live_q       <= '0;
         drop_q       <= '0;
         stale_q      <= 1'b0;
         m_read_q     <= 1'b0;
         m_addr_q     <= '0;
         rdv_q        <= 1'b0;
         rdata_q      <= '0;
      end else begin
         head_valid_q <= head_valid_d;
         head_addr_q  <= head_addr_d;
         fetch_addr_q <= fetch_addr_d;
         live_q       <= live_d;
         drop_q       <= drop_d;
         stale_q      <= stale_d;
         m_read_q     <= m_read_d;
         m_addr_q     <= m_addr_d;
         rdv_q        <= hit;
         if (hit) rdata_q <= fifo_head;
      end
   end

   avalon_prefetch_fifo #(
      .DEPTH      (DEPTH),
      .DATA_WIDTH (DATA_WIDTH),
      .CNT_W      (CNT_W)
   ) u_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .clear_i (clear),
      .push_i  (push),
      .pop_i   (hit),
      .data_i  (m_readdata),
      .data_o  (fifo_head),
      .count_o (buf_cnt)
   );
endmodule

// File: tb/tb_avalon_instr_prefetch.sv
// Scoreboard bench: core-side driver pushes expected words, a monitor pops them on s_readdatavalid.
module tb_avalon_instr_prefetch;
   logic        clk_i = 1'b0;
   logic        rst_i = 1'b1;
   logic        flush_i = 1'b0;
   logic [31:0] s_address = '0;
   logic        s_read = 1'b0;
   logic        s_waitrequest;
   logic [31:0] s_readdata;
   logic        s_readdatavalid;
   logic [31:0] m_address;
   logic        m_read;
   logic        m_waitrequest = 1'b0;
   logic [31:0] m_readdata = '0;
   logic        m_readdatavalid = 1'b0;

   avalon_instr_prefetch #(.DEPTH(4), .ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
      .clk_i           (clk_i),
      .rst_i           (rst_i),
      .flush_i         (flush_i),
      .s_address       (s_address),
      .s_read          (s_read),
      .s_waitrequest   (s_waitrequest),
      .s_readdata      (s_readdata),
      .s_readdatavalid (s_readdatavalid),
      .m_address       (m_address),
      .m_read          (m_read),
      .m_waitrequest   (m_waitrequest),
      .m_readdata      (m_readdata),
      .m_readdatavalid (m_readdatavalid)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic [31:0] addr;
      int          due;
   } req_t;

   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   int          lat = 2;
   int          st_from = -1;
   int          st_to = -1;
   logic [31:0] salt = 32'h5A5A_0000;
   logic [31:0] exp_q[$];
   logic [31:0] alog[$];
   req_t        fq[$];
   logic        held_prev = 1'b0;
   logic [31:0] held_addr = '0;
   int          last_waits;
   logic        last_first_ws;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a ^ salt;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic chk_log(input string name, input int base, input int k, input logic [31:0] exp);
      if (alog.size() <= base + k) begin
         checks++;
         errors++;
         $display("FAIL %s: fetch #%0d missing, expected %h", name, k, exp);
      end else chk(name, alog[base+k], exp);
   endtask

   always @(posedge clk_i) cyc <= cyc + 1;

   // Fabric model: in-order pipelined responses after lat cycles, optional stall window.
   always @(negedge clk_i) begin
      if (rst_i) begin
         fq.delete();
         m_readdatavalid = 1'b0;
         m_waitrequest   = 1'b0;
         held_prev       = 1'b0;
      end else begin
         if (held_prev) begin
            chk("hold_read", {31'd0, m_read}, 32'd1);
            chk("hold_addr", m_address, held_addr);
         end
         m_waitrequest = (cyc >= st_from) && (cyc < st_to);
         if (m_read && !m_waitrequest) begin
            fq.push_back('{addr: m_address, due: cyc + 1 + lat});
            alog.push_back(m_address);
         end
         held_prev = m_read && m_waitrequest;
         held_addr = m_address;
         m_readdatavalid = 1'b0;
         if (fq.size() > 0 && fq[0].due <= cyc + 1) begin
            m_readdatavalid = 1'b1;
            m_readdata      = mem_word(fq[0].addr);
            void'(fq.pop_front());
         end
      end
   end

   always @(negedge clk_i) begin
      if (!rst_i && s_readdatavalid) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_rdata: got %h with nothing expected", s_readdata);
         end else chk("rdata", s_readdata, exp_q.pop_front());
      end
   end

   task automatic idle(input int n);
      repeat (n) @(posedge clk_i);
      #1;
   endtask

   // Holds a read for n cycles without waiting for completion (core abandons or redirects).
   task automatic pulse(input logic [31:0] a, input int n);
      s_address = a;
      s_read    = 1'b1;
      idle(n);
      s_read = 1'b0;
   endtask

   task automatic core_read(input logic [31:0] a);
      int w;
      w = 0;
      s_address = a;
      s_read    = 1'b1;
      #1;
      last_first_ws = s_waitrequest;
      while (s_waitrequest && w <= 200) begin
         @(posedge clk_i);
         #1;
         w++;
      end
      if (w > 200) begin
         checks++;
         errors++;
         $display("FAIL read_timeout: addr %h still stalled after %0d cycles", a, w);
         s_read = 1'b0;
      end else begin
         exp_q.push_back(mem_word(a));
         @(posedge clk_i);
         #1;
         s_read = 1'b0;
      end
      last_waits = w;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      int base;
      idle(3);
      rst_i = 1'b0;
      @(negedge clk_i);
      chk("rst_m_read", {31'd0, m_read}, 32'd0);
      chk("rst_m_address", m_address, 32'd0);
      chk("rst_rdv", {31'd0, s_readdatavalid}, 32'd0);
      chk("rst_rdata", s_readdata, 32'd0);
      @(posedge clk_i);
      #1;

      // Sequential stream
      base = alog.size();
      core_read(32'h100);
      chk("seq_first_ws", {31'd0, last_first_ws}, 32'd1);
      for (int i = 1; i < 4; i++) begin
         core_read(32'h100 + i);
         chk("seq_hit_waits", last_waits, 32'd0);
      end
      idle(20);
      for (int k = 0; k < 8; k++) chk_log("seq_fetch", base, k, 32'h100 + k);
      chk("seq_fetch_count", alog.size() - base, 32'd8);

      // Redirect with three requests in flight
      lat = 8;
      base = alog.size();
      pulse(32'h200, 3);
      core_read(32'h500);
      chk("redir_first_ws", {31'd0, last_first_ws}, 32'd1);
      chk_log("redir_fetch", base, 0, 32'h200);
      chk_log("redir_fetch", base, 1, 32'h201);
      chk_log("redir_fetch", base, 2, 32'h202);
      chk_log("redir_fetch", base, 3, 32'h500);
      core_read(32'h501);
      idle(30);

      // Fabric stall with redirect during the hold
      lat = 2;
      base = alog.size();
      st_from = cyc;
      st_to   = cyc + 6;
      pulse(32'h300, 2);
      core_read(32'h400);
      chk_log("stall_fetch", base, 0, 32'h300);
      chk_log("stall_fetch", base, 1, 32'h400);
      core_read(32'h401);
      idle(20);

      // Flush after memory contents change
      pulse(32'h10, 1);
      idle(20);
      salt = 32'hC3C3_0000;
      flush_i = 1'b1;
      idle(1);
      flush_i = 1'b0;
      base = alog.size();
      core_read(32'h10);
      chk("flush_first_ws", {31'd0, last_first_ws}, 32'd1);
      chk_log("flush_fetch", base, 0, 32'h10);
      core_read(32'h11);
      idle(20);

      // Address wrap
      base = alog.size();
      core_read(32'hFFFF_FFFE);
      core_read(32'hFFFF_FFFF);
      core_read(32'h0000_0000);
      core_read(32'h0000_0001);
      chk_log("wrap_fetch", base, 0, 32'hFFFF_FFFE);
      chk_log("wrap_fetch", base, 1, 32'hFFFF_FFFF);
      chk_log("wrap_fetch", base, 2, 32'h0000_0000);
      chk_log("wrap_fetch", base, 3, 32'h0000_0001);
      idle(20);

      // Reset with two buffered and two in flight
      pulse(32'h600, 1);
      idle(4);
      rst_i = 1'b1;
      idle(1);
      rst_i = 1'b0;
      @(negedge clk_i);
      chk("mid_rst_m_read", {31'd0, m_read}, 32'd0);
      chk("mid_rst_rdv", {31'd0, s_readdatavalid}, 32'd0);
      @(posedge clk_i);
      #1;
      base = alog.size();
      core_read(32'h700);
      chk("post_rst_first_ws", {31'd0, last_first_ws}, 32'd1);
      chk_log("post_rst_fetch", base, 0, 32'h700);
      idle(20);

      chk("scoreboard_empty", exp_q.size(), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
